multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the RV32 core. It replaces the single-cycle Control_Unit when the core shares one memory port and one ALU across several cycles per instruction. Each instruction is stepped through fetch, decode, execute, memory and writeback states. The block drives every datapath enable and mux select, and handshakes with the unified memory. The existing ALU_DECODE block is kept downstream: it receives ALU_op from this block and produces ALU_Control.

---
 rtl/multicycle_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle instruction sequencer for the RV32 core: steps each instruction through
// fetch/decode/execute/memory/writeback. Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [2:0] ALU_flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [2:0] ALU_op,
  output logic [1:0] Result_src,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRWB   = 4'd12,
    LUI      = 4'd13
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    TRAP     = 4'd14
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_RFN  = 3'b010;
  localparam logic [2:0] ALUOP_IFN  = 3'b011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_taken;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= state_t'(RESET_STATE);
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken =  ALU_flags[0];
      3'b001:  w_taken = ~ALU_flags[0];
      3'b100:  w_taken =  ALU_flags[1];
      3'b101:  w_taken = ~ALU_flags[1];
      3'b110:  w_taken =  ALU_flags[2];
      3'b111:  w_taken = ~ALU_flags[2];
      default: w_taken = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_ctrl       = '0;

    case (r_state)
      FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.src_a      = SRCA_PC;
        w_ctrl.src_b      = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURES;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next_state    = DECODE;
        end
      end

      DECODE: begin
        w_ctrl.src_a  = SRCA_OLDPC;
        w_ctrl.src_b  = SRCB_IMM;
        w_ctrl.alu_op = ALUOP_ADD;
        if (opcode == OP_BRANCH)   w_ctrl.imm_src = IMM_B;
        else if (opcode == OP_JAL) w_ctrl.imm_src = IMM_J;
        else                       w_ctrl.imm_src = IMM_I;
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = MEMADR;
          OP_RTYPE:          w_next_state = EXECR;
          OP_ITYPE:          w_next_state = EXECI;
          OP_BRANCH:         w_next_state = BRANCH;
          OP_JAL:            w_next_state = JAL;
          OP_JALR:           w_next_state = JALR;
          OP_LUI:            w_next_state = LUI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           w_next_state = TRAP;
`else
          default:           w_next_state = FETCH;
`endif
        endcase
      end

      MEMADR: begin
        w_ctrl.src_a   = SRCA_REGA;
        w_ctrl.src_b   = SRCB_IMM;
        w_ctrl.alu_op  = ALUOP_ADD;
        w_ctrl.imm_src = (opcode == OP_STORE) ? IMM_S : IMM_I;
        w_next_state   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = 1'b1;
        if (mem_ready) w_next_state = MEMWB;
      end

      MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next_state      = FETCH;
      end

      MEMWRITE: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.adr_src   = 1'b1;
        if (mem_ready) begin
          w_ctrl.instr_done = 1'b1;
          w_next_state      = FETCH;
        end
      end

      EXECR: begin
        w_ctrl.src_a  = SRCA_REGA;
        w_ctrl.src_b  = SRCB_REGB;
        w_ctrl.alu_op = ALUOP_RFN;
        w_next_state  = ALUWB;
      end

      EXECI: begin
        w_ctrl.src_a   = SRCA_REGA;
        w_ctrl.src_b   = SRCB_IMM;
        w_ctrl.imm_src = IMM_I;
        w_ctrl.alu_op  = ALUOP_IFN;
        w_next_state   = ALUWB;
      end

      ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next_state      = FETCH;
      end

      BRANCH: begin
        w_ctrl.src_a      = SRCA_REGA;
        w_ctrl.src_b      = SRCB_REGB;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = w_taken;
        w_ctrl.instr_done = 1'b1;
        w_next_state      = FETCH;
      end

      // ALUOut still holds the target from DECODE; this cycle's OldPC+4 replaces it at the edge.
      JAL: begin
        w_ctrl.src_a      = SRCA_OLDPC;
        w_ctrl.src_b      = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
        w_next_state      = ALUWB;
      end

      JALR: begin
        w_ctrl.src_a      = SRCA_REGA;
        w_ctrl.src_b      = SRCB_IMM;
        w_ctrl.imm_src    = IMM_I;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURES;
        w_ctrl.pc_write   = 1'b1;
        w_next_state      = JALRWB;
      end

      JALRWB: begin
        w_ctrl.src_a      = SRCA_OLDPC;
        w_ctrl.src_b      = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURES;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next_state      = FETCH;
      end

      LUI: begin
        w_ctrl.imm_src    = IMM_U;
        w_ctrl.result_src = RES_IMM;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next_state      = FETCH;
      end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      TRAP: begin
        w_ctrl.illegal = 1'b1;
        w_next_state   = TRAP;
      end
`endif

      default: w_next_state = FETCH;
    endcase
  end

  // Reset forces every output low in the same cycle, abandoning any pending access.
  assign w_out = reset ? '0 : w_ctrl;

  assign mem_req    = w_out.mem_req;
  assign MemWrite   = w_out.mem_write;
  assign AdrSrc     = w_out.adr_src;
  assign IRWrite    = w_out.ir_write;
  assign PCWrite    = w_out.pc_write;
  assign RegWrite   = w_out.reg_write;
  assign ImmSrc     = w_out.imm_src;
  assign ALU_SrcA   = w_out.src_a;
  assign ALU_SrcB   = w_out.src_b;
  assign ALU_op     = w_out.alu_op;
  assign Result_src = w_out.result_src;
  assign instr_done = w_out.instr_done;
  assign illegal    = w_out.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control words are queued
// by the stimulus from instruction-level rules and compared by an independent monitor.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
    logic       done;
    logic       illegal;
  } vec_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [2:0] ALU_flags = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [2:0] ImmSrc;
  logic [1:0] ALU_SrcA, ALU_SrcB;
  logic [2:0] ALU_op;
  logic [1:0] Result_src;
  logic       instr_done, illegal;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .ALU_flags  (ALU_flags),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALU_SrcA   (ALU_SrcA),
    .ALU_SrcB   (ALU_SrcB),
    .ALU_op     (ALU_op),
    .Result_src (Result_src),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [2:0] cur_flags;

  function automatic vec_t ctl(input int mr, input int mw, input int adr, input int irw,
                               input int pcw, input int rw, input int imm, input int sa,
                               input int sb, input int aop, input int rs, input int dn,
                               input int il);
    vec_t v;
    v.mem_req    = 1'(mr);
    v.mem_write  = 1'(mw);
    v.adr_src    = 1'(adr);
    v.ir_write   = 1'(irw);
    v.pc_write   = 1'(pcw);
    v.reg_write  = 1'(rw);
    v.imm_src    = 3'(imm);
    v.src_a      = 2'(sa);
    v.src_b      = 2'(sb);
    v.alu_op     = 3'(aop);
    v.result_src = 2'(rs);
    v.done       = 1'(dn);
    v.illegal    = 1'(il);
    return v;
  endfunction

  task automatic check(input vec_t act, input vec_t e, input string nm);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %05h want %05h", nm, act, e);
    end
  endtask

  // Monitor: every cycle the DUT presents a control word; compare against the queued one.
  initial begin
    vec_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
               ALU_SrcA, ALU_SrcB, ALU_op, Result_src, instr_done, illegal};
        check(act, exp_q.pop_front(), name_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; inputs change just after the rising edge.
  task automatic step(input logic rst, input logic rdy, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    opcode    = cur_op;
    funct3    = cur_f3;
    ALU_flags = cur_flags;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] fl);
    case (f3)
      3'd0:    return fl[0];
      3'd1:    return !fl[0];
      3'd4:    return fl[1];
      3'd5:    return !fl[1];
      3'd6:    return fl[2];
      3'd7:    return !fl[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch_decode(input string nm, input int fw);
    int imm;
    for (int i = 0; i < fw; i++)
      step(0, 0, ctl(1,0,0,0,0,0, 0,0,2,0,2,0,0), {nm, "_fetch_wait"});
    step(0, 1, ctl(1,0,0,1,1,0, 0,0,2,0,2,0,0), {nm, "_fetch"});
    imm = (cur_op == OP_BRANCH) ? 2 : (cur_op == OP_JAL) ? 3 : 0;
    step(0, rnd_bit(), ctl(0,0,0,0,0,0, imm,1,1,0,0,0,0), {nm, "_decode"});
  endtask

  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [2:0] fl, input int fw, input int mw);
    cur_op = op; cur_f3 = f3; cur_flags = fl;
    fetch_decode(nm, fw);
    case (op)
      OP_LOAD: begin
        step(0, rnd_bit(), ctl(0,0,0,0,0,0, 0,2,1,0,0,0,0), {nm, "_memadr"});
        for (int i = 0; i < mw; i++)
          step(0, 0, ctl(1,0,1,0,0,0, 0,0,0,0,0,0,0), {nm, "_read_wait"});
        step(0, 1, ctl(1,0,1,0,0,0, 0,0,0,0,0,0,0), {nm, "_read"});
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 0,0,0,0,1,1,0), {nm, "_memwb"});
      end
      OP_STORE: begin
        step(0, rnd_bit(), ctl(0,0,0,0,0,0, 1,2,1,0,0,0,0), {nm, "_memadr"});
        for (int i = 0; i < mw; i++)
          step(0, 0, ctl(1,1,1,0,0,0, 0,0,0,0,0,0,0), {nm, "_write_wait"});
        step(0, 1, ctl(1,1,1,0,0,0, 0,0,0,0,0,1,0), {nm, "_write"});
      end
      OP_RTYPE: begin
        step(0, rnd_bit(), ctl(0,0,0,0,0,0, 0,2,0,2,0,0,0), {nm, "_execr"});
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 0,0,0,0,0,1,0), {nm, "_aluwb"});
      end
      OP_ITYPE: begin
        step(0, rnd_bit(), ctl(0,0,0,0,0,0, 0,2,1,3,0,0,0), {nm, "_execi"});
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 0,0,0,0,0,1,0), {nm, "_aluwb"});
      end
      OP_BRANCH: begin
        step(0, rnd_bit(), ctl(0,0,0,0,int'(branch_taken(f3, fl)),0, 0,2,0,1,0,1,0),
             {nm, "_branch"});
      end
      OP_JAL: begin
        step(0, rnd_bit(), ctl(0,0,0,0,1,0, 0,1,2,0,0,0,0), {nm, "_jal"});
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 0,0,0,0,0,1,0), {nm, "_aluwb"});
      end
      OP_JALR: begin
        step(0, rnd_bit(), ctl(0,0,0,0,1,0, 0,2,1,0,2,0,0), {nm, "_jalr"});
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 0,1,2,0,2,1,0), {nm, "_jalrwb"});
      end
      OP_LUI: begin
        step(0, rnd_bit(), ctl(0,0,0,0,0,1, 4,0,0,0,3,1,0), {nm, "_lui"});
      end
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] ops [8];
    string      names [8];
    int         k;
    vec_t       zero;
    ops   = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    names = '{"lw", "sw", "rtype", "itype", "branch", "jal", "jalr", "lui"};
    zero  = '0;
    cur_op = '0; cur_f3 = '0; cur_flags = '0;

    step(1, 0, zero, "reset_a");
    step(1, 1, zero, "reset_b");

    run_instr("add",       OP_RTYPE,  3'd0, 3'b000, 0, 0);
    run_instr("lw_wait2",  OP_LOAD,   3'd2, 3'b000, 0, 2);
    run_instr("beq_z1",    OP_BRANCH, 3'd0, 3'b001, 0, 0);
    run_instr("beq_z0",    OP_BRANCH, 3'd0, 3'b110, 0, 0);
    run_instr("bgeu_c1",   OP_BRANCH, 3'd7, 3'b100, 0, 0);
    run_instr("bgeu_c0",   OP_BRANCH, 3'd7, 3'b011, 0, 0);
    run_instr("b_f3_010",  OP_BRANCH, 3'd2, 3'b111, 1, 0);
    run_instr("jal",       OP_JAL,    3'd0, 3'b000, 0, 0);
    run_instr("jalr",      OP_JALR,   3'd0, 3'b000, 0, 0);
    run_instr("lui",       OP_LUI,    3'd0, 3'b000, 0, 0);
    run_instr("sw_wait1",  OP_STORE,  3'd2, 3'b000, 2, 1);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 7);
      run_instr($sformatf("rnd%0d_%s", n, names[k]), ops[k], 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Store abandoned by reset during its second wait cycle.
    cur_op = OP_STORE; cur_f3 = 3'd2; cur_flags = 3'b000;
    fetch_decode("sw_rst", 0);
    step(0, 0, ctl(0,0,0,0,0,0, 1,2,1,0,0,0,0), "sw_rst_memadr");
    step(0, 0, ctl(1,1,1,0,0,0, 0,0,0,0,0,0,0), "sw_rst_wait1");
    step(1, 0, zero, "sw_rst_wait2_in_reset");
    step(1, 0, zero, "sw_rst_after");
    run_instr("post_rst_add", OP_ITYPE, 3'd0, 3'b000, 0, 0);

    // Unknown opcode.
    cur_op = 7'b1111111; cur_f3 = 3'd0; cur_flags = 3'b000;
    fetch_decode("illegal", 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step(0, rnd_bit(), ctl(0,0,0,0,0,0, 0,0,0,0,0,0,1), "illegal_trap");
    step(1, 0, zero, "illegal_reset");
    run_instr("post_trap_lui", OP_LUI, 3'd0, 3'b000, 0, 0);
`else
    step(0, 1, ctl(1,0,0,1,1,0, 0,0,2,0,2,0,0), "illegal_nop_fetch");
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
